// File: rtl/ps_filter.sv
// ps_filter: inline zero-latency PacketStream per-packet filter.
// Each packet is passed, dropped whole or truncated to a programmable length.
// The action is sampled on the first word and held for the rest of the packet.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   mode, maxlen       per-packet action (0 pass, 1 drop, 2 truncate, 3 pass)
//                      and truncate length, sampled on the first word
//   clear              synchronous clear of the statistics counters
//   wremoved           a word is discarded this cycle
//   premoved           pulse on the accepted eop of a dropped packet
//   ptruncated         pulse on the accepted eop of a truncated packet
//   pass/drop/trunc_cnt  saturating packet statistics
//   i_* / o_*          inbound / outbound PacketStream (dat, val, eop, rdy)
module ps_filter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LWIDTH = 16,
    parameter int unsigned CWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [LWIDTH-1:0] maxlen,
    input  logic              clear,
    output logic              wremoved,
    output logic              premoved,
    output logic              ptruncated,
    output logic [CWIDTH-1:0] pass_cnt,
    output logic [CWIDTH-1:0] drop_cnt,
    output logic [CWIDTH-1:0] trunc_cnt,
    input  logic [WIDTH-1:0]  i_dat,
    input  logic              i_val,
    input  logic              i_eop,
    output logic              i_rdy,
    output logic [WIDTH-1:0]  o_dat,
    output logic              o_val,
    output logic              o_eop,
    input  logic              o_rdy
);

    typedef enum logic [1:0] {
        ACT_PASS  = 2'd0,
        ACT_DROP  = 2'd1,
        ACT_TRUNC = 2'd2
    } act_t;

    logic              sop;
    logic [LWIDTH-1:0] wcnt;
    act_t              hmode;
    logic [LWIDTH-1:0] hmax;

    act_t              new_act;
    act_t              act;
    logic [LWIDTH-1:0] lim;
    logic              fwd;
    logic              force_eop;
    logic              acc;
    logic              eop_acc;
    logic              pass_inc;

    // Effective action: live inputs on the first word, held registers after.
    always_comb begin
        new_act = ACT_PASS;
        case (mode)
            2'd1:    new_act = ACT_DROP;
            2'd2:    new_act = (maxlen == '0) ? ACT_DROP : ACT_TRUNC;
            default: new_act = ACT_PASS;
        endcase
        act       = sop ? new_act : hmode;
        lim       = sop ? maxlen : hmax;
        fwd       = (act == ACT_PASS) || ((act == ACT_TRUNC) && (wcnt < lim));
        force_eop = (act == ACT_TRUNC) && (wcnt == lim - LWIDTH'(1));
    end

    // Stream path and status; everything is held quiet while in reset.
    always_comb begin
        o_dat      = i_dat;
        o_val      = reset & fwd & i_val;
        o_eop      = reset & fwd & (i_eop | force_eop);
        i_rdy      = reset & (fwd ? o_rdy : 1'b1);
        wremoved   = reset & ~fwd & i_val;
        acc        = i_val & i_rdy;
        eop_acc    = acc & i_eop;
        // Discarding is monotonic within a packet, so a truncate-mode packet
        // was cut exactly when its eop word itself is discarded.
        premoved   = eop_acc & (act == ACT_DROP);
        ptruncated = eop_acc & (act == ACT_TRUNC) & ~fwd;
        pass_inc   = eop_acc & fwd;
    end

    // Packet tracking: first-word flag, held decision, word index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sop   <= 1'b1;
            wcnt  <= '0;
            hmode <= ACT_PASS;
            hmax  <= '0;
        end else if (acc) begin
            sop <= i_eop;
            if (sop) begin
                hmode <= new_act;
                hmax  <= maxlen;
            end
            if (i_eop) begin
                wcnt <= '0;
            end else if (!(&wcnt)) begin
                wcnt <= wcnt + LWIDTH'(1);
            end
        end
    end

    // Saturating statistics; clear wins over a coincident increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_cnt  <= '0;
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else if (clear) begin
            pass_cnt  <= '0;
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (pass_inc && !(&pass_cnt)) begin
                pass_cnt <= pass_cnt + CWIDTH'(1);
            end
            if (premoved && !(&drop_cnt)) begin
                drop_cnt <= drop_cnt + CWIDTH'(1);
            end
            if (ptruncated && !(&trunc_cnt)) begin
                trunc_cnt <= trunc_cnt + CWIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps_filter.sv
// Self-checking bench for ps_filter: directed packets plus randomized traffic,
// checked against a packet-level reference of the filter rules.
module tb_ps_filter;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned LWIDTH = 16;
    localparam int unsigned CWIDTH = 4;
    localparam int          CMAX   = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic [LWIDTH-1:0] maxlen;
    logic              clear;
    logic              wremoved, premoved, ptruncated;
    logic [CWIDTH-1:0] pass_cnt, drop_cnt, trunc_cnt;
    logic [WIDTH-1:0]  i_dat, o_dat;
    logic              i_val, i_eop, i_rdy, o_val, o_eop, o_rdy;

    int total = 0;
    int bad   = 0;
    int m_pass = 0, m_drop = 0, m_trunc = 0;
    logic [WIDTH-1:0] expq[$];
    logic [WIDTH-1:0] obsq[$];

    ps_filter #(.WIDTH(WIDTH), .LWIDTH(LWIDTH), .CWIDTH(CWIDTH)) dut (
        .clk(clk), .reset(reset), .mode(mode), .maxlen(maxlen), .clear(clear),
        .wremoved(wremoved), .premoved(premoved), .ptruncated(ptruncated),
        .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x < CMAX) ? x + 1 : CMAX;
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_pass"},  32'(pass_cnt),  32'(m_pass));
        chk({tag, "_drop"},  32'(drop_cnt),  32'(m_drop));
        chk({tag, "_trunc"}, 32'(trunc_cnt), 32'(m_trunc));
    endtask

    // Send one packet. vmode: 0 valid always high, 1 random valid.
    // rmode: 0 o_rdy high, 1 o_rdy low, 2 random. stop_after >= 0 abandons
    // the packet after that many accepted words.
    task automatic send_pkt(input int len, input logic [1:0] md, input int ml,
                            input int vmode, input int rmode, input bit mid_chg,
                            input bit clr_last, input int stop_after);
        int  cls;
        int  guard;
        bit  last, keep, done, exp_rdy, acc;
        logic [WIDTH-1:0] d;
        // Packet-level class: 0 pass, 1 drop, 2 truncate.
        cls = (md == 2'd1) ? 1 : (md == 2'd2) ? ((ml == 0) ? 1 : 2) : 0;
        expq.delete();
        obsq.delete();
        for (int idx = 0; idx < len; idx++) begin
            if (stop_after >= 0 && idx >= stop_after) break;
            last  = (idx == len - 1);
            keep  = (cls == 0) || (cls == 2 && idx < ml);
            d     = WIDTH'($urandom);
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                @(negedge clk);
                i_dat = d;
                i_eop = last;
                i_val = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                o_rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                clear = clr_last && last;
                if (idx == 0) begin
                    mode   = md;
                    maxlen = LWIDTH'(ml);
                end else if (mid_chg) begin
                    mode   = 2'($urandom);
                    maxlen = LWIDTH'($urandom_range(0, 5));
                end
                #1;
                exp_rdy = keep ? o_rdy : 1'b1;
                acc     = i_val && exp_rdy;
                chk("o_dat",    32'(o_dat),    32'(i_dat));
                chk("o_val",    32'(o_val),    32'(i_val && keep));
                chk("i_rdy",    32'(i_rdy),    32'(exp_rdy));
                chk("wremoved", 32'(wremoved), 32'(i_val && !keep));
                chk("premoved", 32'(premoved), 32'(acc && last && cls == 1));
                chk("ptrunc",   32'(ptruncated), 32'(acc && last && cls == 2 && len > ml));
                if (keep) chk("o_eop", 32'(o_eop), 32'(last || (cls == 2 && idx == ml - 1)));
                if (o_val && o_rdy) obsq.push_back(o_dat);
                if (acc && keep) expq.push_back(d);
                @(posedge clk);
                if (clear) begin
                    m_pass = 0; m_drop = 0; m_trunc = 0;
                end else if (acc && last) begin
                    if (cls == 1)            m_drop  = sat(m_drop);
                    else if (cls == 2 && len > ml) m_trunc = sat(m_trunc);
                    else                     m_pass  = sat(m_pass);
                end
                if (acc) done = 1'b1;
                guard++;
                if (!done && guard > 200) begin
                    chk("timeout", 32'(guard), 32'(0));
                    done = 1'b1;
                end
            end
        end
        @(negedge clk);
        i_val = 1'b0;
        clear = 1'b0;
        #1;
        if (stop_after < 0) begin
            chk_counters("cnt");
            chk("sb_len", 32'(obsq.size()), 32'(expq.size()));
            for (int i = 0; i < obsq.size() && i < expq.size(); i++)
                chk("sb_dat", 32'(obsq[i]), 32'(expq[i]));
        end
    endtask

    initial begin
        reset  = 1'b0;
        mode   = 2'd0;
        maxlen = '0;
        clear  = 1'b0;
        i_dat  = '0;
        i_val  = 1'b1;
        i_eop  = 1'b0;
        o_rdy  = 1'b1;

        // Reset state with traffic presented.
        #3;
        chk("rst_i_rdy", 32'(i_rdy), 32'(0));
        chk("rst_o_val", 32'(o_val), 32'(0));
        chk("rst_o_eop", 32'(o_eop), 32'(0));
        chk("rst_wrem",  32'(wremoved), 32'(0));
        chk_counters("rst");
        @(negedge clk);
        @(negedge clk);
        i_val = 1'b0;
        reset = 1'b1;

        // Plain pass.
        for (int p = 0; p < 3; p++) send_pkt(4, 2'd0, 0, 0, 0, 1'b0, 1'b0, -1);
        chk("pass3", 32'(pass_cnt), 32'(3));

        // Drop under full backpressure.
        send_pkt(5, 2'd1, 0, 0, 1, 1'b0, 1'b0, -1);
        chk("drop1", 32'(drop_cnt), 32'(1));

        // Truncate 10 words to 3.
        send_pkt(10, 2'd2, 3, 0, 0, 1'b0, 1'b0, -1);
        chk("trunc1", 32'(trunc_cnt), 32'(1));

        // Truncate boundaries.
        send_pkt(3, 2'd2, 3, 0, 0, 1'b0, 1'b0, -1);
        send_pkt(2, 2'd2, 0, 0, 0, 1'b0, 1'b0, -1);
        send_pkt(1, 2'd2, 1, 0, 0, 1'b0, 1'b0, -1);
        send_pkt(4, 2'd3, 0, 0, 0, 1'b0, 1'b0, -1);

        // Randomized traffic with mid-packet mode changes and stalls.
        for (int p = 0; p < 40; p++)
            send_pkt($urandom_range(1, 8), 2'($urandom), $urandom_range(0, 5),
                     1, 2, 1'b1, 1'b0, -1);

        // Drive drop counter into saturation.
        for (int p = 0; p < 17; p++) send_pkt(1, 2'd1, 0, 0, 0, 1'b0, 1'b0, -1);
        chk("drop_sat", 32'(drop_cnt), 32'(CMAX));

        // Clear coincident with an eop wins.
        send_pkt(2, 2'd0, 0, 0, 0, 1'b0, 1'b1, -1);
        chk("clr_pass", 32'(pass_cnt), 32'(0));

        // Reset mid-packet, then a fresh first-word decision.
        send_pkt(6, 2'd0, 0, 0, 0, 1'b0, 1'b0, 3);
        reset = 1'b0;
        i_val = 1'b1;
        o_rdy = 1'b1;
        #1;
        chk("mid_rst_i_rdy", 32'(i_rdy), 32'(0));
        chk("mid_rst_o_val", 32'(o_val), 32'(0));
        m_pass = 0; m_drop = 0; m_trunc = 0;
        chk_counters("mid_rst");
        @(negedge clk);
        i_val = 1'b0;
        reset = 1'b1;
        send_pkt(4, 2'd2, 2, 0, 0, 1'b0, 1'b0, -1);
        chk("post_rst_trunc", 32'(trunc_cnt), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
